fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port stall, input, 1, hazard hold request: PC and the IF/ID register keep their values.
REQ-004 SHALL have port BrTaken, input, 1, branch-taken indication from the decode stage.
REQ-005 SHALL have port new_PC2, input, 64, branch target computed by the decode stage.
REQ-006 SHALL have port imem_data, input, 32, combinational instruction memory read data for imem_addr.
REQ-007 SHALL have port imem_addr, output, 64, current PC driven to instruction memory.
REQ-008 SHALL have port PC, output, 64, PC of the instruction held in IF/ID.
REQ-009 SHALL have port instr_id, output, 32, instruction held in IF/ID.
REQ-010 SHALL have port BLT, output, 64, PC + 4 of the IF/ID instruction (branch-link value).
REQ-011 SHALL have port valid_id, output, 1, high when IF/ID holds a real fetched instruction.
REQ-012 SHALL have port fetch_count, output, 32, count of instructions loaded into IF/ID with valid_id = 1.

Function
REQ-013 SHALL implement FSM states BOOT, RUN, HOLD and BUBBLE; the state alone determines valid_id (1 in RUN; held value in HOLD; 0 in BOOT and BUBBLE).
REQ-014 SHALL compute next PC with priority reset > stall > BrTaken > sequential: reset gives 0; stall holds; BrTaken gives new_PC2; otherwise PC + 4, wrapping modulo 2^64.
REQ-015 SHALL ignore BrTaken in any cycle with stall = 1, because decode re-asserts it after the stall releases.
REQ-016 SHALL, when not stalled and BrTaken = 0, load IF/ID with {imem_addr, imem_data} and enter RUN.
REQ-017 SHALL, on stall = 1, enter HOLD and keep IF/ID, PC, valid_id and fetch_count unchanged.
REQ-018 SHALL, on leaving HOLD, resume per REQ-014/REQ-016 with no instruction lost or duplicated.
REQ-019 SHALL have a fetch latency of one cycle: the instruction at address A appears on instr_id in the cycle after imem_addr = A.
REQ-020 SHALL compute BLT as the IF/ID PC + 4 with 64-bit wrap.
REQ-021 SHALL increment fetch_count by 1 on each IF/ID load that has valid_id = 1, wrapping from 2^32-1 to 0, and hold it otherwise.

Reset
REQ-022 SHALL, on reset, set imem_addr = 0, PC = 0, BLT = 4, instr_id = NOP_INSTR, valid_id = 0, fetch_count = 0 and state = BOOT.
REQ-023 SHALL give reset priority over stall and BrTaken in the same cycle, including reset asserted mid-stall or mid-flush.

Configuration
REQ-024 SHALL, with macro BR_DELAY_SLOT_EN defined, handle BrTaken with stall = 0 by loading the sequentially fetched instruction into IF/ID as valid (delay slot executed), then redirecting PC.
REQ-025 SHALL, without BR_DELAY_SLOT_EN, handle BrTaken with stall = 0 by loading IF/ID with NOP_INSTR, valid_id = 0 and state BUBBLE (flush), then redirecting PC; fetch_count does not increment.

Structure
REQ-026 SHALL place NOP_INSTR (32'h8B1F03FF, ADD XZR,XZR,XZR), PC_STEP (64'd4), RESET_PC (64'd0) and the FSM state enum typedef in shared package cpu_pkg.
REQ-027 SHALL use the existing adder64 for PC + 4 and use one new sub-module, if_id_reg (IF/ID register with load-enable and flush), for the pipeline register.

Verification
REQ-028 SHALL cover reset then free run with imem returning instr = addr: imem_addr 0, 4, 8; instr_id 0 then 4 one cycle later; valid_id rising in cycle 2; fetch_count = 3 after three loads.
REQ-029 SHALL cover stall for 3 cycles at imem_addr = 0x10: imem_addr, PC = 0xC and fetch_count frozen, then 0x14 fetched on release.
REQ-030 SHALL cover BrTaken = 1 with new_PC2 = 0x100 at imem_addr = 0x20: next imem_addr = 0x100; IF/ID holds NOP with valid_id = 0, or holds 0x20 with valid_id = 1 under BR_DELAY_SLOT_EN.
REQ-031 SHALL cover stall = 1 and BrTaken = 1 together: PC held; branch honoured only in the first unstalled cycle.
REQ-032 SHALL cover reset asserted during HOLD with PC = 0x40: next cycle imem_addr = 0, valid_id = 0, fetch_count = 0, state BOOT.
REQ-033 SHALL cover PC wrap with new_PC2 = 64'hFFFF_FFFF_FFFF_FFFC: next sequential imem_addr = 0 and BLT = 0 for that instruction.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage FSM state type.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h8B1F03FF;  // ADD XZR,XZR,XZR
    localparam logic [63:0] PC_STEP   = 64'd4;
    localparam logic [63:0] RESET_PC  = 64'd0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        BUBBLE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/adder64.sv
// 64-bit combinational adder; the carry out is dropped, so sums wrap modulo 2^64.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load enable and flush-to-NOP.
// Priority: srst > hold (load_en = 0) > flush > load.
import cpu_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        srst,
    input  logic        load_en,
    input  logic        flush,
    input  logic [63:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [63:0] pc,
    output logic [31:0] instr
);

    logic [63:0] pc_reg;
    logic [31:0] instr_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_INSTR;
        end else if (load_en) begin
            pc_reg    <= pc_in;
            instr_reg <= flush ? NOP_INSTR : instr_in;
        end
    end

    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and fetch FSM.
// Define BR_DELAY_SLOT_EN to execute the delay-slot instruction instead of flushing on a taken branch.
import cpu_pkg::*;

module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        BrTaken,
    input  logic [63:0] new_PC2,
    input  logic [31:0] imem_data,
    output logic [63:0] imem_addr,
    output logic [63:0] PC,
    output logic [31:0] instr_id,
    output logic [63:0] BLT,
    output logic        valid_id,
    output logic [31:0] fetch_count
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic [63:0] pc_plus4;
    logic [31:0] fetch_count_reg;
    logic [31:0] fetch_count_next;
    logic        valid_hold_reg;
    logic        branch_flush;
    logic        load_valid;

`ifdef BR_DELAY_SLOT_EN
    assign branch_flush = 1'b0;
`else
    assign branch_flush = BrTaken;
`endif

    // A branch seen while stalled is dropped; decode re-asserts it afterwards.
    assign load_valid = !stall && !branch_flush;

    adder64 u_pc_adder (
        .a   (pc_reg),
        .b   (PC_STEP),
        .sum (pc_plus4)
    );

    adder64 u_blt_adder (
        .a   (PC),
        .b   (PC_STEP),
        .sum (BLT)
    );

    if_id_reg u_if_id (
        .clk      (clk),
        .srst     (reset),
        .load_en  (!stall),
        .flush    (branch_flush),
        .pc_in    (pc_reg),
        .instr_in (imem_data),
        .pc       (PC),
        .instr    (instr_id)
    );

    always_comb begin
        pc_next = pc_plus4;
        if (stall) begin
            pc_next = pc_reg;
        end else if (BrTaken) begin
            pc_next = new_PC2;
        end
    end

    always_comb begin
        fetch_count_next = fetch_count_reg;
        if (load_valid) begin
            fetch_count_next = fetch_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            fetch_count_reg <= 32'd0;
            valid_hold_reg  <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            fetch_count_reg <= fetch_count_next;
            if (stall) begin
                valid_hold_reg <= valid_id;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = RUN;
        if (stall) begin
            state_next = HOLD;
        end else if (branch_flush) begin
            state_next = BUBBLE;
        end
    end

    // FSM: outputs
    always_comb begin
        valid_id = 1'b0;
        case (state_reg)
            RUN:     valid_id = 1'b1;
            HOLD:    valid_id = valid_hold_reg;
            default: valid_id = 1'b0;
        endcase
    end

    assign imem_addr   = pc_reg;
    assign fetch_count = fetch_count_reg;

endmodule
